verificador_jogada: RTL and testbench

- Sits directly downstream of the four button debouncers of the Genius game.
- Consumes their one-cycle "apertado" press pulses and checks each press, in order, against the stored colour sequence for the current round.
- Enforces a per-press timeout.
- Reports success, error or timeout to the game controller FSM as single-cycle pulses.

---
 rtl/genius_pkg.sv | 35 +++
 rtl/codificador_cor.sv | 18 +
 rtl/verificador_jogada.sv | 110 +++++++++++
 tb/tb_verificador_jogada.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared Genius types: colour codes, FSM states and the one-hot button encoder.
package genius_pkg;

   typedef logic [1:0] cor_t;

   localparam cor_t COR_VERDE    = 2'd0;
   localparam cor_t COR_VERMELHO = 2'd1;
   localparam cor_t COR_AZUL     = 2'd2;
   localparam cor_t COR_AMARELO  = 2'd3;

   localparam int unsigned MAX_LEN_PADRAO = 32;

   typedef struct packed {
      logic valido;
      cor_t cor;
   } cor_dec_t;

   typedef enum logic {StOcioso, StEspera} estado_t;

   // valido is set only for exactly one button pressed
   function automatic cor_dec_t codifica_onehot(input logic [3:0] a);
      cor_dec_t r;
      r.valido = 1'b1;
      r.cor    = COR_VERDE;
      case (a)
         4'b0001: r.cor = COR_VERDE;
         4'b0010: r.cor = COR_VERMELHO;
         4'b0100: r.cor = COR_AZUL;
         4'b1000: r.cor = COR_AMARELO;
         default: r.valido = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/codificador_cor.sv
// Classifies the debounced button vector: single press (with colour) or multiple press.
module codificador_cor
   import genius_pkg::*;
(
   input  logic [3:0] apertado,
   output logic [1:0] cor,
   output logic       um_quente,
   output logic       multiplo
);

   cor_dec_t dec;

   assign dec       = codifica_onehot(apertado);
   assign cor       = dec.cor;
   assign um_quente = dec.valido;
   assign multiplo  = (|apertado) & ~dec.valido;

endmodule

// File: rtl/verificador_jogada.sv
// Checks button presses against the stored colour sequence with a per-press timeout.
module verificador_jogada
   import genius_pkg::*;
#(
   parameter int unsigned MAX_LEN        = MAX_LEN_PADRAO,
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned TIMEOUT_CYCLES = 250000000,
   parameter int unsigned TMR_W          = 28
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   seq_len,
   input  logic [3:0]        apertado,
   output logic [ADDR_W-1:0] seq_addr,
   input  logic [1:0]        seq_cor,
   output logic              ocupado,
   output logic              tecla,
   output logic [1:0]        cor_pressionada,
   output logic              acertou,
   output logic              errou,
   output logic              tempo_esgotado
);

   localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(MAX_LEN);
   localparam logic [ADDR_W:0]   LEN_UM    = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] IDX_UM    = ADDR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_UM    = TMR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_CARGA = TMR_W'(TIMEOUT_CYCLES - 1);

   estado_t           estado_q;
   logic [ADDR_W-1:0] indice_q;
   logic [ADDR_W:0]   len_q;
   logic [TMR_W-1:0]  timer_q;

   logic [1:0] cor_apertada;
   logic       um_quente;
   logic       multiplo;
   logic       ultima;
   logic       len_valido;

   codificador_cor u_codificador_cor (
      .apertado  (apertado),
      .cor       (cor_apertada),
      .um_quente (um_quente),
      .multiplo  (multiplo)
   );

   assign seq_addr   = indice_q;
   assign ultima     = ({1'b0, indice_q} == (len_q - LEN_UM));
   assign len_valido = (seq_len != '0) && (seq_len <= LEN_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q        <= StOcioso;
         indice_q        <= '0;
         len_q           <= '0;
         timer_q         <= '0;
         ocupado         <= 1'b0;
         tecla           <= 1'b0;
         cor_pressionada <= '0;
         acertou         <= 1'b0;
         errou           <= 1'b0;
         tempo_esgotado  <= 1'b0;
      end else begin
         tecla          <= 1'b0;
         acertou        <= 1'b0;
         errou          <= 1'b0;
         tempo_esgotado <= 1'b0;
         case (estado_q)
            StOcioso: begin
               if (start && len_valido) begin
                  len_q    <= seq_len;
                  indice_q <= '0;
                  timer_q  <= TMR_CARGA;
                  ocupado  <= 1'b1;
                  estado_q <= StEspera;
               end
            end
            StEspera: begin
               // A press always wins over an expiring timer in the same cycle
               if (multiplo || (um_quente && (cor_apertada != seq_cor))) begin
                  errou    <= 1'b1;
                  ocupado  <= 1'b0;
                  estado_q <= StOcioso;
               end else if (um_quente) begin
                  tecla           <= 1'b1;
                  cor_pressionada <= cor_apertada;
                  if (ultima) begin
                     acertou  <= 1'b1;
                     ocupado  <= 1'b0;
                     estado_q <= StOcioso;
                  end else begin
                     indice_q <= indice_q + IDX_UM;
                     timer_q  <= TMR_CARGA;
                  end
               end else if (timer_q == '0) begin
                  tempo_esgotado <= 1'b1;
                  ocupado        <= 1'b0;
                  estado_q       <= StOcioso;
               end else begin
                  timer_q <= timer_q - TMR_UM;
               end
            end
            default: estado_q <= StOcioso;
         endcase
      end
   end

endmodule

// File: tb/tb_verificador_jogada.sv
// Directed bench: expected response pulses are queued on stimulus and checked as they appear.
module tb_verificador_jogada;

   localparam int unsigned TO = 20;

   typedef struct packed {
      logic       tecla;
      logic [1:0] cor;
      logic       acertou;
      logic       errou;
      logic       tempo;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [5:0] seq_len = '0;
   logic [3:0] apertado = '0;
   logic [4:0] seq_addr;
   logic [1:0] seq_cor;
   logic       ocupado, tecla, acertou, errou, tempo_esgotado;
   logic [1:0] cor_pressionada;

   ev_t        sb[$];
   ev_t        mon_e;
   ev_t        mon_obs;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [1:0] last_cor = 2'd0;

   verificador_jogada #(
      .MAX_LEN        (32),
      .ADDR_W         (5),
      .TIMEOUT_CYCLES (TO),
      .TMR_W          (28)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .seq_len         (seq_len),
      .apertado        (apertado),
      .seq_addr        (seq_addr),
      .seq_cor         (seq_cor),
      .ocupado         (ocupado),
      .tecla           (tecla),
      .cor_pressionada (cor_pressionada),
      .acertou         (acertou),
      .errou           (errou),
      .tempo_esgotado  (tempo_esgotado)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] store(input logic [4:0] a);
      case (a)
         5'd0:    return 2'd2;
         5'd1:    return 2'd0;
         5'd2:    return 2'd3;
         5'd3:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] code_of(input logic [3:0] a);
      case (a)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   assign seq_cor = store(seq_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && (tecla | acertou | errou | tempo_esgotado)) begin
         mon_obs = {tecla, cor_pressionada, acertou, errou, tempo_esgotado};
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {27'b0, mon_obs}, 32'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("event", {27'b0, mon_obs}, {27'b0, mon_e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [5:0] n);
      seq_len = n;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic press_ok(input logic [3:0] a, input logic fim);
      last_cor = code_of(a);
      sb.push_back({1'b1, last_cor, fim, 1'b0, 1'b0});
      apertado = a;
      tick();
      apertado = '0;
   endtask

   task automatic press_err(input logic [3:0] a);
      sb.push_back({1'b0, last_cor, 1'b0, 1'b1, 1'b0});
      apertado = a;
      tick();
      apertado = '0;
   endtask

   task automatic drain(input string tag);
      tick();
      tick();
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      int found;

      // Reset state
      #12;
      chk("rst_ocupado", {31'b0, ocupado}, 0);
      chk("rst_addr", {27'b0, seq_addr}, 0);
      chk("rst_pulses", {28'b0, tecla, acertou, errou, tempo_esgotado}, 0);
      chk("rst_cor", {30'b0, cor_pressionada}, 0);
      #1 reset = 1'b1;
      tick();

      // Happy path: 2,0,3,1
      do_start(6'd4);
      chk("hp_ocupado", {31'b0, ocupado}, 1);
      chk("hp_addr0", {27'b0, seq_addr}, 0);
      press_ok(4'b0100, 1'b0);
      repeat (4) tick();
      chk("hp_addr1", {27'b0, seq_addr}, 1);
      press_ok(4'b0001, 1'b0);
      repeat (4) tick();
      press_ok(4'b1000, 1'b0);
      repeat (4) tick();
      chk("hp_addr3", {27'b0, seq_addr}, 3);
      press_ok(4'b0010, 1'b1);
      tick();
      chk("hp_ocupado_fim", {31'b0, ocupado}, 0);
      chk("hp_addr_hold", {27'b0, seq_addr}, 3);
      drain("hp_drain");

      // Wrong colour at index 1
      do_start(6'd4);
      press_ok(4'b0100, 1'b0);
      repeat (2) tick();
      chk("wc_addr", {27'b0, seq_addr}, 1);
      press_err(4'b0010);
      tick();
      chk("wc_ocupado", {31'b0, ocupado}, 0);
      chk("wc_addr_hold", {27'b0, seq_addr}, 1);
      drain("wc_drain");

      // Multiple buttons, one of them correct
      do_start(6'd4);
      press_err(4'b0101);
      tick();
      chk("mp_ocupado", {31'b0, ocupado}, 0);
      drain("mp_drain");

      // Plain timeout: TO edges after the start edge
      sb.push_back({1'b0, last_cor, 1'b0, 1'b0, 1'b1});
      do_start(6'd2);
      found = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (tempo_esgotado === 1'b1 && found < 0) found = k;
      end
      chk("to_latency", found, TO);
      chk("to_ocupado", {31'b0, ocupado}, 0);
      drain("to_drain");

      // Press on edge 19 reloads the timer
      do_start(6'd2);
      repeat (18) tick();
      press_ok(4'b0100, 1'b0);
      chk("tr_addr", {27'b0, seq_addr}, 1);
      sb.push_back({1'b0, last_cor, 1'b0, 1'b0, 1'b1});
      found = -1;
      for (int k = 20; k <= 50; k++) begin
         tick();
         if (tempo_esgotado === 1'b1 && found < 0) found = k;
      end
      chk("tr_latency", found, 39);
      drain("tr_drain");

      // Press on the edge where the timer reads zero
      do_start(6'd2);
      repeat (19) tick();
      press_ok(4'b0100, 1'b0);
      tick();
      chk("col_ocupado", {31'b0, ocupado}, 1);
      press_ok(4'b0001, 1'b1);
      drain("col_drain");

      // Invalid lengths are ignored
      do_start(6'd0);
      chk("len0_ocupado", {31'b0, ocupado}, 0);
      do_start(6'd33);
      chk("len33_ocupado", {31'b0, ocupado}, 0);

      // start during ESPERA does not restart
      do_start(6'd4);
      press_ok(4'b0100, 1'b0);
      chk("re_addr_a", {27'b0, seq_addr}, 1);
      do_start(6'd2);
      chk("re_addr_b", {27'b0, seq_addr}, 1);
      chk("re_ocupado", {31'b0, ocupado}, 1);
      press_ok(4'b0001, 1'b0);
      chk("re_addr_c", {27'b0, seq_addr}, 2);
      tick();

      // Asynchronous reset mid-round
      #2 reset = 1'b0;
      #1;
      chk("ar_ocupado", {31'b0, ocupado}, 0);
      chk("ar_addr", {27'b0, seq_addr}, 0);
      chk("ar_cor", {30'b0, cor_pressionada}, 0);
      chk("ar_pulses", {28'b0, tecla, acertou, errou, tempo_esgotado}, 0);
      last_cor = 2'd0;
      #3 reset = 1'b1;
      tick();

      // Presses while idle produce nothing
      apertado = 4'b0100;
      tick();
      apertado = 4'b0001;
      tick();
      apertado = '0;
      tick();
      chk("idle_ocupado", {31'b0, ocupado}, 0);
      drain("idle_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
